mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM-to-WB memory stage with a data-memory handshake, alignment check and ack timeout.
// Ports: clk, reset (async, active high); in_* are the EX/MEM pipeline values;
// mem_req/mem_we/mem_addr/mem_wdata and mem_ack/mem_rdata form the data-memory port;
// stall holds upstream stages; out_* are the MEM/WB values;
// misaligned_err is a one-cycle pulse and timeout_err is sticky until reset.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_RegWrite,
    input  logic        in_MemtoReg,
    input  logic [31:0] in_ALUResult,
    input  logic [31:0] in_ReadData2,
    input  logic [4:0]  in_WriteReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        out_valid,
    output logic        out_RegWrite,
    output logic [4:0]  out_WriteReg,
    output logic [31:0] out_WriteData,
    output logic        misaligned_err,
    output logic        timeout_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;
    logic [8:0] cnt;
    logic mem_op, aligned, start, expire;
    assign mem_op  = in_valid && (in_MemRead || in_MemWrite);
    assign aligned = in_ALUResult[1:0] == 2'b00;
    assign start   = state == IDLE && mem_op && aligned;
    // The last waiting cycle is the one whose increment would bring the counter to TIMEOUT,
    // so exactly TIMEOUT ACCESS cycles are spent before giving up.
    assign expire  = state == ACCESS && !mem_ack && cnt == 9'(TIMEOUT - 1);
    assign mem_req = state == ACCESS;
    assign stall   = !reset && (start || (state == ACCESS && !mem_ack && !expire));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (start) state_nxt = ACCESS;
        else if (state == ACCESS && (mem_ack || expire)) state_nxt = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cnt            <= '0;
            out_valid      <= 1'b0;
            out_RegWrite   <= 1'b0;
            out_WriteReg   <= '0;
            out_WriteData  <= '0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            misaligned_err <= 1'b0;
            if (start) begin
                mem_addr     <= in_ALUResult;
                mem_wdata    <= in_ReadData2;
                mem_we       <= in_MemWrite;
                cnt          <= '0;
                out_valid    <= 1'b0;
                out_RegWrite <= 1'b0;
            end else if (state == ACCESS) begin
                if (mem_ack) begin
                    out_valid     <= 1'b1;
                    out_RegWrite  <= in_RegWrite && !in_MemWrite;
                    out_WriteReg  <= in_WriteReg;
                    out_WriteData <= in_MemtoReg ? mem_rdata : in_ALUResult;
                end else if (expire) begin
                    out_valid    <= 1'b1;
                    out_RegWrite <= 1'b0;
                    timeout_err  <= 1'b1;
                end else begin
                    cnt          <= cnt + 9'd1;
                    out_valid    <= 1'b0;
                    out_RegWrite <= 1'b0;
                end
            end else if (!in_valid) begin
                out_valid    <= 1'b0;
                out_RegWrite <= 1'b0;
            end else if (mem_op) begin
                // Misaligned access: retire without touching memory and without writeback.
                out_valid      <= 1'b1;
                out_RegWrite   <= 1'b0;
                misaligned_err <= 1'b1;
            end else begin
                out_valid     <= 1'b1;
                out_RegWrite  <= in_RegWrite;
                out_WriteReg  <= in_WriteReg;
                out_WriteData <= in_ALUResult;
            end
        end
    end
endmodule
